// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined mixed-sign multiplier.
package mul_pkg;

  typedef struct packed {
    logic signed_A;
    logic signed_B;
  } mul_sign_t;

  // Widest product the negate helper can handle; callers zero-extend then truncate.
  localparam int unsigned MaxWidth = 256;

  function automatic int unsigned calc_stage_bits(input int unsigned data_width,
                                                  input int unsigned depth);
    return data_width / depth;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic logic [MaxWidth-1:0] two_comp_negate(input logic [MaxWidth-1:0] v);
    return ~v + MaxWidth'(1);
  endfunction

endpackage

// File: rtl/mixed_sign_mul_stage.sv
// Combinational shift-add step: consumes P multiplier bits and retires P product bits.
module mixed_sign_mul_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned P          = 4
) (
  input  logic [DATA_WIDTH-1:0] i_mag_a,
  input  logic [P-1:0]          i_b_bits,
  input  logic [DATA_WIDTH-1:0] i_pp,
  input  logic                  i_carry,
  output logic [DATA_WIDTH-1:0] o_pp,
  output logic                  o_carry,
  output logic [P-1:0]          o_ret
);

  always_comb begin
    logic [DATA_WIDTH:0] acc;
    logic [DATA_WIDTH:0] sum;
    acc   = {i_carry, i_pp};
    sum   = '0;
    o_ret = '0;
    // acc stays below 2^DATA_WIDTH after each shift, so the sum never overflows.
    for (int j = 0; j < int'(P); j++) begin
      sum      = acc + (i_b_bits[j] ? {1'b0, i_mag_a} : '0);
      o_ret[j] = sum[0];
      acc      = {1'b0, sum[DATA_WIDTH:1]};
    end
    {o_carry, o_pp} = acc;
  end

endmodule

// File: rtl/pipelined_mixed_sign_multiplier.sv
// Pipelined long multiplier with per-operand signedness, valid/ready backpressure,
// synchronous flush and a passthrough tag.
module pipelined_mixed_sign_multiplier
  import mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PIPELINE_DEPTH = 4,
  parameter int unsigned TAG_WIDTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   operand_A_i,
  input  logic [DATA_WIDTH-1:0]   operand_B_i,
  input  logic                    signed_A_i,
  input  logic                    signed_B_i,
  input  logic [TAG_WIDTH-1:0]    tag_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [2*DATA_WIDTH-1:0] result_o,
  output logic [TAG_WIDTH-1:0]    tag_o
);

  localparam int unsigned P      = calc_stage_bits(DATA_WIDTH, PIPELINE_DEPTH);
  localparam int unsigned ProdW  = 2 * DATA_WIDTH;
  localparam int unsigned NumMid = PIPELINE_DEPTH - 1;

  if (!is_pow2(DATA_WIDTH) || DATA_WIDTH < 4 || ProdW > MaxWidth) begin : g_bad_width
    $error("DATA_WIDTH must be a power of 2 between 4 and %0d", MaxWidth / 2);
  end
  if (PIPELINE_DEPTH < 2 || PIPELINE_DEPTH > DATA_WIDTH ||
      (DATA_WIDTH % PIPELINE_DEPTH) != 0) begin : g_bad_depth
    $error("PIPELINE_DEPTH must divide DATA_WIDTH and lie in 2..DATA_WIDTH");
  end

  mul_sign_t             w_sign;
  logic                  w_neg_a, w_neg_b, w_advance;
  logic [DATA_WIDTH-1:0] w_mag_a, w_mag_b;
  logic [ProdW-1:0]      w_prod, w_result;

  logic [PIPELINE_DEPTH-1:0] r_valid;
  logic [ProdW-1:0]          r_result;
  logic [TAG_WIDTH-1:0]      r_tag_out;

  // Registers between stage k and stage k+1; the last stage feeds the output register.
  logic [DATA_WIDTH-1:0] r_mag_a [NumMid];
  logic [DATA_WIDTH-1:0] r_mag_b [NumMid];
  logic [DATA_WIDTH-1:0] r_pp    [NumMid];
  logic                  r_carry [NumMid];
  logic [DATA_WIDTH-1:0] r_lo    [NumMid];
  logic                  r_neg   [NumMid];
  logic [TAG_WIDTH-1:0]  r_tag   [NumMid];

  logic [DATA_WIDTH-1:0] w_a_in      [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] w_b_in      [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] w_pp_in     [PIPELINE_DEPTH];
  logic                  w_carry_in  [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] w_lo_in     [PIPELINE_DEPTH];
  logic                  w_neg_in    [PIPELINE_DEPTH];
  logic [TAG_WIDTH-1:0]  w_tag_in    [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] w_pp_out    [PIPELINE_DEPTH];
  logic                  w_carry_out [PIPELINE_DEPTH];
  logic [P-1:0]          w_ret       [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] w_lo_out    [PIPELINE_DEPTH];

  assign w_sign  = '{signed_A: signed_A_i, signed_B: signed_B_i};
  assign w_neg_a = w_sign.signed_A & operand_A_i[DATA_WIDTH-1];
  assign w_neg_b = w_sign.signed_B & operand_B_i[DATA_WIDTH-1];
  assign w_mag_a = w_neg_a ? DATA_WIDTH'(two_comp_negate(MaxWidth'(operand_A_i))) : operand_A_i;
  assign w_mag_b = w_neg_b ? DATA_WIDTH'(two_comp_negate(MaxWidth'(operand_B_i))) : operand_B_i;

  assign w_advance = !valid_o || ready_i;
  assign ready_o   = w_advance;

  for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_a_in[k]     = w_mag_a;
      assign w_b_in[k]     = w_mag_b;
      assign w_pp_in[k]    = '0;
      assign w_carry_in[k] = 1'b0;
      assign w_lo_in[k]    = '0;
      assign w_neg_in[k]   = w_neg_a ^ w_neg_b;
      assign w_tag_in[k]   = tag_i;
    end else begin : g_rest
      assign w_a_in[k]     = r_mag_a[k-1];
      assign w_b_in[k]     = r_mag_b[k-1];
      assign w_pp_in[k]    = r_pp[k-1];
      assign w_carry_in[k] = r_carry[k-1];
      assign w_lo_in[k]    = r_lo[k-1];
      assign w_neg_in[k]   = r_neg[k-1];
      assign w_tag_in[k]   = r_tag[k-1];
    end

    mixed_sign_mul_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .P         (P)
    ) u_stage (
      .i_mag_a (w_a_in[k]),
      .i_b_bits(w_b_in[k][k*P +: P]),
      .i_pp    (w_pp_in[k]),
      .i_carry (w_carry_in[k]),
      .o_pp    (w_pp_out[k]),
      .o_carry (w_carry_out[k]),
      .o_ret   (w_ret[k])
    );

    assign w_lo_out[k] = w_lo_in[k] | (DATA_WIDTH'(w_ret[k]) << (k * P));
  end

  // The final carry is always zero; it falls off the top of the exact 2N-bit product.
  assign w_prod   = ProdW'({w_carry_out[PIPELINE_DEPTH-1], w_pp_out[PIPELINE_DEPTH-1],
                            w_lo_out[PIPELINE_DEPTH-1]});
  assign w_result = w_neg_in[PIPELINE_DEPTH-1] ? ProdW'(two_comp_negate(MaxWidth'(w_prod)))
                                               : w_prod;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid <= {r_valid[PIPELINE_DEPTH-2:0], valid_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < int'(NumMid); k++) begin
        r_mag_a[k] <= '0;
        r_mag_b[k] <= '0;
        r_pp[k]    <= '0;
        r_carry[k] <= 1'b0;
        r_lo[k]    <= '0;
        r_neg[k]   <= 1'b0;
        r_tag[k]   <= '0;
      end
      r_result  <= '0;
      r_tag_out <= '0;
    end else if (w_advance) begin
      for (int k = 0; k < int'(NumMid); k++) begin
        r_mag_a[k] <= w_a_in[k];
        r_mag_b[k] <= w_b_in[k];
        r_pp[k]    <= w_pp_out[k];
        r_carry[k] <= w_carry_out[k];
        r_lo[k]    <= w_lo_out[k];
        r_neg[k]   <= w_neg_in[k];
        r_tag[k]   <= w_tag_in[k];
      end
      r_result  <= w_result;
      r_tag_out <= w_tag_in[PIPELINE_DEPTH-1];
    end
  end

  assign valid_o  = r_valid[PIPELINE_DEPTH-1];
  assign result_o = r_result;
  assign tag_o    = r_tag_out;

endmodule

// File: tb/tb_pipelined_mixed_sign_multiplier.sv
// Directed bench for the 16-bit, 4-stage mixed-sign multiplier.
module tb_pipelined_mixed_sign_multiplier;

  logic        clk_i, rst_i, flush_i, valid_i, ready_o, signed_A_i, signed_B_i;
  logic        valid_o, ready_i;
  logic [15:0] operand_A_i, operand_B_i;
  logic [3:0]  tag_i, tag_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_mixed_sign_multiplier #(
    .DATA_WIDTH    (16),
    .PIPELINE_DEPTH(4),
    .TAG_WIDTH     (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .operand_A_i(operand_A_i),
    .operand_B_i(operand_B_i),
    .signed_A_i (signed_A_i),
    .signed_B_i (signed_B_i),
    .tag_i      (tag_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .tag_o      (tag_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sa;
    logic        sb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sa,
                       input logic sb, input logic [3:0] tag);
    operand_A_i = a;
    operand_B_i = b;
    signed_A_i  = sa;
    signed_B_i  = sb;
    tag_i       = tag;
    valid_i     = 1'b1;
  endtask

  // One request with ready_i=1; lat counts cycles from acceptance cycle to valid_o.
  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic sa,
                         input logic sb, input logic [3:0] tag, output logic [31:0] res,
                         output logic [3:0] rtag, output int lat);
    @(posedge clk_i); #1;
    drive(a, b, sa, sb, tag);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
    res  = result_o;
    rtag = tag_o;
  endtask

  logic [31:0] res;
  logic [3:0]  rtag;
  int          lat;

  logic [15:0] bp_a[6];
  logic [15:0] bp_b[6];
  logic [31:0] bp_exp[6];

  initial begin
    vecs[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001};
    vecs[1]  = '{16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'h00000001};
    vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'hFFFF0001};
    vecs[4]  = '{16'h0003, 16'hFFFE, 1'b1, 1'b1, 32'hFFFFFFFA};
    vecs[5]  = '{16'h1234, 16'h0002, 1'b0, 1'b0, 32'h00002468};
    vecs[6]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 32'hC0008000};
    vecs[7]  = '{16'h0000, 16'hFFFF, 1'b1, 1'b1, 32'h00000000};
    vecs[8]  = '{16'hFFFF, 16'h8000, 1'b0, 1'b1, 32'h80008000};
    vecs[9]  = '{16'h00FF, 16'h0100, 1'b1, 1'b1, 32'h0000FF00};
    vecs[10] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 32'hFFFF8000};
    for (int i = 0; i < 6; i++) begin
      bp_a[i]   = 16'h1000 + 16'(i * 273);
      bp_b[i]   = 16'(5 + i);
      bp_exp[i] = 32'(bp_a[i]) * 32'(bp_b[i]);
    end

    rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    operand_A_i = '0; operand_B_i = '0; signed_A_i = 1'b0; signed_B_i = 1'b0; tag_i = '0;
    #1 rst_i = 1'b1;
    #2;
    check("reset_valid_o", 64'(valid_o), 64'd0);
    check("reset_result_o", 64'(result_o), 64'd0);
    check("reset_tag_o", 64'(tag_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("reset_ready_o", 64'(ready_o), 64'd1);

    // Table-driven single operations
    for (int i = 0; i < 11; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, 4'(i), res, rtag, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_tag", i), 64'(rtag), 64'(i));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
    end

    // Backpressure: ready_i low for 10 cycles while six requests are offered
    begin
      int  next_req = 0;
      int  n_got = 0;
      int  first_c = -1;
      int  last_c = -1;
      logic will_acc;
      @(posedge clk_i); #1;
      for (int cyc = 0; cyc < 40 && n_got < 6; cyc++) begin
        ready_i = (cyc >= 10);
        if (next_req < 6) drive(bp_a[next_req], bp_b[next_req], 1'b0, 1'b0, 4'(next_req));
        else valid_i = 1'b0;
        @(negedge clk_i);
        will_acc = valid_i && ready_o;
        if (cyc >= 4 && cyc < 10) begin
          check($sformatf("stall_valid_c%0d", cyc), 64'(valid_o), 64'd1);
          check($sformatf("stall_result_c%0d", cyc), 64'(result_o), 64'(bp_exp[0]));
          check($sformatf("stall_tag_c%0d", cyc), 64'(tag_o), 64'd0);
        end
        if (cyc == 9) begin
          check("stall_accept_count", 64'(next_req), 64'd4);
          check("stall_ready_o", 64'(ready_o), 64'd0);
        end
        if (valid_o && ready_i) begin
          if (n_got < 6) begin
            check($sformatf("bp_tag%0d", n_got), 64'(tag_o), 64'(n_got));
            check($sformatf("bp_result%0d", n_got), 64'(result_o), 64'(bp_exp[n_got]));
          end
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          n_got++;
        end
        @(posedge clk_i); #1;
        if (will_acc) next_req++;
      end
      valid_i = 1'b0;
      check("bp_results_seen", 64'(n_got), 64'd6);
      check("bp_accepted", 64'(next_req), 64'd6);
      check("bp_no_bubble", 64'(last_c - first_c), 64'd5);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check("bp_drained", 64'(valid_o), 64'd0);
    end

    // Flush with three requests in flight and a fourth offered in the flush cycle
    begin
      int spurious = 0;
      ready_i = 1'b1;
      @(posedge clk_i); #1;
      for (int c = 0; c < 4; c++) begin
        drive(16'h0011 + 16'(c), 16'h0002, 1'b0, 1'b0, 4'(c + 1));
        flush_i = (c == 3);
        @(negedge clk_i);
        if (valid_o) spurious++;
        if (c == 3) check("flush_ready_o", 64'(ready_o), 64'd1);
        @(posedge clk_i); #1;
      end
      flush_i = 1'b0;
      drive(16'h0007, 16'h0009, 1'b0, 1'b0, 4'd9);
      @(negedge clk_i);
      if (valid_o) spurious++;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 20) begin
        @(posedge clk_i); #1;
        lat++;
      end
      check("flush_post_latency", 64'(lat), 64'd4);
      check("flush_post_result", 64'(result_o), 64'h3F);
      check("flush_post_tag", 64'(tag_o), 64'd9);
      check("flush_no_spurious", 64'(spurious), 64'd0);
      @(posedge clk_i); #1;
      check("flush_drained", 64'(valid_o), 64'd0);
    end

    // Asynchronous reset mid-stream with a held result and another request in flight
    ready_i = 1'b0;
    @(posedge clk_i); #1;
    drive(16'h00AA, 16'h0003, 1'b0, 1'b0, 4'd6);
    @(posedge clk_i); #1;
    drive(16'h0101, 16'h0003, 1'b0, 1'b0, 4'd7);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("prereset_valid_o", 64'(valid_o), 64'd1);
    check("prereset_result", 64'(result_o), 64'h1FE);
    #2 rst_i = 1'b1;
    #1;
    check("midreset_valid_o", 64'(valid_o), 64'd0);
    check("midreset_result_o", 64'(result_o), 64'd0);
    check("midreset_tag_o", 64'(tag_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("postreset_ready_o", 64'(ready_o), 64'd1);
    ready_i = 1'b1;
    run_one(16'h1234, 16'h0002, 1'b0, 1'b0, 4'd3, res, rtag, lat);
    check("postreset_result", 64'(res), 64'h2468);
    check("postreset_tag", 64'(rtag), 64'd3);
    check("postreset_latency", 64'(lat), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
